instr_fetch_unit: RTL and testbench

- Front-end stage of the z8 core. Owns the program counter and drives it into the memory manager's `pc` input.
- Samples the combinationally returned 40-bit `current_instruction` and presents it to decode through a registered valid/ready handshake.
- Handles branch redirects and flushes, downstream back-pressure, and a HALT-opcode stop/resume.

---
 rtl/instr_fetch_unit_pkg.sv | 20 ++
 rtl/instr_fetch_unit_if.sv | 31 +++
 rtl/instr_fetch_unit.sv | 94 +++++++++
 tb/tb_instr_fetch_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared instruction-set definitions used by the z8 fetch front end.
// Opcode field bounds, the HALT opcode and fetch-stage types.
package instruction_set;

    localparam int OPCODE_MSB = 39;
    localparam int OPCODE_LSB = 32;

    localparam logic [7:0] OP_HALT = 8'h76;

    typedef enum logic {
        FETCH,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [39:0] instr;
    } fetch_bundle_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch bus: PC/instruction exchange with the memory manager plus the
// valid/ready instruction handshake towards decode.
interface instr_fetch_unit_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 40
);
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr_in;
    logic               out_ready;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;

    modport master (
        output pc,
        input  instr_in,
        input  out_ready,
        output out_valid,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  pc,
        output instr_in,
        output out_ready,
        input  out_valid,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, registers the returned instruction for decode,
// and handles redirects, back-pressure and HALT stop/resume.
module instr_fetch_unit
    import instruction_set::*;
#(
    parameter int              PC_W       = 16,
    parameter int              INSTR_W    = 40,
    parameter int              PROG_DEPTH = 256,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  bus,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    input  logic                resume,
    output logic                halted
);

    // PROG_DEPTH is a power of two, so wrapping is a simple mask
    localparam logic [PC_W-1:0] PC_MASK = PC_W'(PROG_DEPTH - 1);

    fetch_state_t       state, state_next;
    logic [PC_W-1:0]    pc_reg, pc_next;
    logic               valid_reg, valid_next;
    logic [INSTR_W-1:0] instr_reg, instr_next;
    logic [PC_W-1:0]    opc_reg, opc_next;
    logic               accept;
    logic               is_halt;

    assign accept  = !valid_reg || bus.out_ready;
    assign is_halt = (bus.instr_in[OPCODE_MSB:OPCODE_LSB] == OP_HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pc_reg    <= RESET_PC & PC_MASK;
            valid_reg <= 1'b0;
            instr_reg <= '0;
            opc_reg   <= '0;
        end else begin
            state     <= state_next;
            pc_reg    <= pc_next;
            valid_reg <= valid_next;
            instr_reg <= instr_next;
            opc_reg   <= opc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc_reg;
        valid_next = valid_reg;
        instr_next = instr_reg;
        opc_next   = opc_reg;

        // A redirect flushes whatever is held, even a stalled or HALT word
        if (redirect_valid) begin
            pc_next    = redirect_pc & PC_MASK;
            valid_next = 1'b0;
            state_next = FETCH;
        end else begin
            unique case (state)
                FETCH: begin
                    if (accept) begin
                        instr_next = bus.instr_in;
                        opc_next   = pc_reg;
                        valid_next = 1'b1;
                        pc_next    = (pc_reg + PC_W'(1)) & PC_MASK;
                        if (is_halt) begin
                            state_next = HALTED;
                        end
                    end
                end
                HALTED: begin
                    if (valid_reg && bus.out_ready) begin
                        valid_next = 1'b0;
                    end
                    if (resume) begin
                        state_next = FETCH;
                    end
                end
                default: state_next = FETCH;
            endcase
        end
    end

    assign bus.pc        = pc_reg;
    assign bus.out_valid = valid_reg;
    assign bus.out_instr = instr_reg;
    assign bus.out_pc    = opc_reg;
    assign halted        = (state == HALTED);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a combinational
// program memory model whose word at address 7 is a HALT.
module tb_instr_fetch_unit;
    import instruction_set::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        resume;
    logic        halted;

    int checks   = 0;
    int failures = 0;
    int addr5_xfers = 0;

    instr_fetch_unit_if #(.PC_W(16), .INSTR_W(40)) bus_if ();

    instr_fetch_unit #(
        .PC_W(16), .INSTR_W(40), .PROG_DEPTH(256), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .resume(resume),
        .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] word_at(input logic [15:0] a);
        logic [7:0] op;
        op = (a[7:0] == 8'd7) ? OP_HALT : 8'h10;
        return {op, 16'hC0DE, 8'h5A, a[7:0]};
    endfunction

    always_comb bus_if.instr_in = word_at(bus_if.pc);

    always @(posedge clk) begin
        if (!reset && bus_if.out_valid && bus_if.out_ready && bus_if.out_pc == 16'h0005)
            addr5_xfers = addr5_xfers + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        resume = 1'b0;
        bus_if.out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset_and_stream();
        do_reset();
        checks++; if (bus_if.pc !== 16'h0) begin failures++; $display("FAIL reset_pc actual=%h required=0000", bus_if.pc); end
        checks++; if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b required=0", bus_if.out_valid); end
        checks++; if (bus_if.out_instr !== 40'h0) begin failures++; $display("FAIL reset_instr actual=%h required=0", bus_if.out_instr); end
        checks++; if (bus_if.out_pc !== 16'h0) begin failures++; $display("FAIL reset_out_pc actual=%h required=0000", bus_if.out_pc); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted actual=%b required=0", halted); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (bus_if.out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] actual=%b required=1", k, bus_if.out_valid); end
            checks++; if (bus_if.out_pc !== 16'(k)) begin failures++; $display("FAIL stream_out_pc[%0d] actual=%h required=%h", k, bus_if.out_pc, 16'(k)); end
            checks++; if (bus_if.out_instr !== word_at(16'(k))) begin failures++; $display("FAIL stream_instr[%0d] actual=%h required=%h", k, bus_if.out_instr, word_at(16'(k))); end
            checks++; if (bus_if.pc !== 16'(k + 1)) begin failures++; $display("FAIL stream_pc[%0d] actual=%h required=%h", k, bus_if.pc, 16'(k + 1)); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step(); step();
        checks++; if (bus_if.out_pc !== 16'h2) begin failures++; $display("FAIL stall_setup actual=%h required=0002", bus_if.out_pc); end
        bus_if.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_pc !== 16'h2 || bus_if.out_instr !== word_at(16'h2) || bus_if.pc !== 16'h3) begin
                failures++; $display("FAIL stall_hold[%0d] actual=v%b opc=%h pc=%h required=v1 opc=0002 pc=0003", k, bus_if.out_valid, bus_if.out_pc, bus_if.pc);
            end
        end
        bus_if.out_ready = 1'b1;
        step();
        checks++; if (bus_if.out_pc !== 16'h3 || bus_if.out_instr !== word_at(16'h3) || bus_if.pc !== 16'h4) begin
            failures++; $display("FAIL stall_release actual=opc=%h pc=%h required=opc=0003 pc=0004", bus_if.out_pc, bus_if.pc);
        end
    endtask

    task automatic test_redirect_in_stall();
        step(); step();
        checks++; if (bus_if.out_pc !== 16'h5 || bus_if.pc !== 16'h6) begin failures++; $display("FAIL redir_setup actual=opc=%h pc=%h required=opc=0005 pc=0006", bus_if.out_pc, bus_if.pc); end
        bus_if.out_ready = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect_valid = 1'b0;
        bus_if.out_ready = 1'b1;
        checks++; if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL redir_flush actual=%b required=0", bus_if.out_valid); end
        checks++; if (bus_if.pc !== 16'h0040) begin failures++; $display("FAIL redir_pc actual=%h required=0040", bus_if.pc); end
        step();
        checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_pc !== 16'h0040 || bus_if.out_instr !== word_at(16'h0040)) begin
            failures++; $display("FAIL redir_target actual=v%b opc=%h required=v1 opc=0040", bus_if.out_valid, bus_if.out_pc);
        end
        checks++; if (addr5_xfers !== 0) begin failures++; $display("FAIL redir_no_xfer5 actual=%0d required=0", addr5_xfers); end
    endtask

    task automatic test_halt_resume();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0005;
        step();
        redirect_valid = 1'b0;
        step(); step(); step();
        checks++; if (bus_if.out_pc !== 16'h7 || bus_if.out_valid !== 1'b1 || bus_if.out_instr !== word_at(16'h7)) begin
            failures++; $display("FAIL halt_word actual=v%b opc=%h required=v1 opc=0007", bus_if.out_valid, bus_if.out_pc);
        end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag actual=%b required=1", halted); end
        checks++; if (bus_if.pc !== 16'h8) begin failures++; $display("FAIL halt_pc actual=%h required=0008", bus_if.pc); end
        for (int k = 0; k < 10; k++) begin
            step();
            checks++; if (bus_if.out_valid !== 1'b0 || bus_if.pc !== 16'h8 || halted !== 1'b1) begin
                failures++; $display("FAIL halt_frozen[%0d] actual=v%b pc=%h h%b required=v0 pc=0008 h1", k, bus_if.out_valid, bus_if.pc, halted);
            end
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        checks++; if (halted !== 1'b0 || bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL resume_first actual=h%b v%b required=h0 v0", halted, bus_if.out_valid); end
        step();
        checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_pc !== 16'h8 || bus_if.pc !== 16'h9) begin
            failures++; $display("FAIL resume_fetch actual=v%b opc=%h pc=%h required=v1 opc=0008 pc=0009", bus_if.out_valid, bus_if.out_pc, bus_if.pc);
        end
    endtask

    task automatic test_resume_with_redirect();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0007;
        step();
        redirect_valid = 1'b0;
        step(); step();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL rr_halted actual=%b required=1", halted); end
        resume = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0020;
        step();
        resume = 1'b0;
        redirect_valid = 1'b0;
        checks++; if (bus_if.pc !== 16'h0020 || halted !== 1'b0 || bus_if.out_valid !== 1'b0) begin
            failures++; $display("FAIL rr_redirect_wins actual=pc=%h h%b v%b required=pc=0020 h0 v0", bus_if.pc, halted, bus_if.out_valid);
        end
        step();
        checks++; if (bus_if.out_pc !== 16'h0020 || bus_if.out_valid !== 1'b1) begin failures++; $display("FAIL rr_target actual=opc=%h v%b required=opc=0020 v1", bus_if.out_pc, bus_if.out_valid); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc = 16'h01FE;
        step();
        redirect_valid = 1'b0;
        checks++; if (bus_if.pc !== 16'h00FE || bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL wrap_mask actual=pc=%h v%b required=pc=00fe v0", bus_if.pc, bus_if.out_valid); end
        step();
        checks++; if (bus_if.out_pc !== 16'h00FE || bus_if.pc !== 16'h00FF) begin failures++; $display("FAIL wrap_fe actual=opc=%h pc=%h required=opc=00fe pc=00ff", bus_if.out_pc, bus_if.pc); end
        step();
        checks++; if (bus_if.out_pc !== 16'h00FF || bus_if.pc !== 16'h0000) begin failures++; $display("FAIL wrap_ff actual=opc=%h pc=%h required=opc=00ff pc=0000", bus_if.out_pc, bus_if.pc); end
        step();
        checks++; if (bus_if.out_pc !== 16'h0000 || bus_if.out_instr !== word_at(16'h0) || bus_if.pc !== 16'h0001) begin
            failures++; $display("FAIL wrap_00 actual=opc=%h pc=%h required=opc=0000 pc=0001", bus_if.out_pc, bus_if.pc);
        end
    endtask

    task automatic test_redirect_on_transfer();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0030;
        step();
        redirect_valid = 1'b0;
        checks++; if (bus_if.out_valid !== 1'b0 || bus_if.pc !== 16'h0030) begin failures++; $display("FAIL xfer_redirect actual=v%b pc=%h required=v0 pc=0030", bus_if.out_valid, bus_if.pc); end
    endtask

    task automatic test_reset_mid_stall();
        bus_if.out_ready = 1'b0;
        step(); step();
        checks++; if (bus_if.out_valid !== 1'b1) begin failures++; $display("FAIL rst_setup actual=%b required=1", bus_if.out_valid); end
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0055;
        step();
        reset = 1'b0;
        redirect_valid = 1'b0;
        checks++; if (bus_if.out_valid !== 1'b0 || bus_if.pc !== 16'h0000 || halted !== 1'b0 || bus_if.out_pc !== 16'h0000) begin
            failures++; $display("FAIL rst_mid_stall actual=v%b pc=%h h%b opc=%h required=v0 pc=0000 h0 opc=0000", bus_if.out_valid, bus_if.pc, halted, bus_if.out_pc);
        end
    endtask

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        resume = 1'b0;
        bus_if.out_ready = 1'b0;
        test_reset_and_stream();
        test_stall();
        test_redirect_in_stall();
        test_halt_resume();
        test_resume_with_redirect();
        test_wrap();
        test_redirect_on_transfer();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
